// File: rtl/uart_receiver_if.sv
// Serial receive bundle: the line into the receiver and the recovered byte
// with its strobe, error flags and busy indication coming back out.
interface uart_receiver_if ();
    logic       RX_datain;
    logic [7:0] RX_DATA;
    logic       RX_valid;
    logic       parity_error;
    logic       framing_error;
    logic       RX_busy;

    // Side that drives the serial line and consumes the decoded result.
    modport master (
        output RX_datain,
        input  RX_DATA,
        input  RX_valid,
        input  parity_error,
        input  framing_error,
        input  RX_busy
    );

    // The receiver itself.
    modport slave (
        input  RX_datain,
        output RX_DATA,
        output RX_valid,
        output parity_error,
        output framing_error,
        output RX_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: start, 8 data bits LSB first, even parity, stop.
// RX_datain must already be synchronous to clk; there is no synchroniser here.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave rx_if
);
    localparam int unsigned CntW     = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HalfBit  = (CLKS_PER_BIT - 1) / 2;
    // A counter loaded with k samples on the (k+1)th following edge.
    localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'((HalfBit > 0) ? HalfBit - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;

    logic rx;
    logic sample_now;

    assign rx         = rx_if.RX_datain;
    assign sample_now = (cnt_q == '0);

    // Next-state and registered-output computation for the frame FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        unique case (state_q)
            StIdle: begin
                if (!rx) begin
                    bit_d = '0;
                    // With no half-bit wait the detection edge is the start check.
                    if (HalfBit == 0) begin
                        state_d = StData;
                        cnt_d   = BitLoad;
                    end else begin
                        state_d = StStart;
                        cnt_d   = HalfLoad;
                    end
                end
            end
            StStart: begin
                if (sample_now) begin
                    if (rx) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = BitLoad;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StData: begin
                if (sample_now) begin
                    shift_d = {rx, shift_q[7:1]};
                    cnt_d   = BitLoad;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StParity;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StParity: begin
                if (sample_now) begin
                    par_d   = rx;
                    cnt_d   = BitLoad;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStop: begin
                if (sample_now) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = (^shift_q) ^ par_q;
                    ferr_d  = ~rx;
                    state_d = rx ? StIdle : StBreak;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StBreak: begin
                // Wait out a held-low line so it is not mistaken for a new start.
                if (rx) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_if.RX_DATA       = data_q;
    assign rx_if.RX_valid      = valid_q;
    assign rx_if.parity_error  = perr_q;
    assign rx_if.framing_error = ferr_q;
    assign rx_if.RX_busy       = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 1, 4 and 16 clocks per bit. Frames are built
// from byte/parity/stop values; expected results and strobe timing come from
// the frame rules and are matched against every RX_valid strobe.
module tb_uart_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [2:0] rx_line;
    logic [2:0] valid_w, busy_w, perr_w, ferr_w;
    logic [7:0] data_w [3];

    uart_receiver_if if_n1 ();
    uart_receiver_if if_n4 ();
    uart_receiver_if if_n16 ();

    uart_receiver #(.CLKS_PER_BIT(1))  u_dut_n1  (.clk(clk), .reset(reset), .rx_if(if_n1.slave));
    uart_receiver #(.CLKS_PER_BIT(4))  u_dut_n4  (.clk(clk), .reset(reset), .rx_if(if_n4.slave));
    uart_receiver #(.CLKS_PER_BIT(16)) u_dut_n16 (.clk(clk), .reset(reset), .rx_if(if_n16.slave));

    assign if_n1.RX_datain  = rx_line[0];
    assign if_n4.RX_datain  = rx_line[1];
    assign if_n16.RX_datain = rx_line[2];

    assign valid_w = {if_n16.RX_valid, if_n4.RX_valid, if_n1.RX_valid};
    assign busy_w  = {if_n16.RX_busy, if_n4.RX_busy, if_n1.RX_busy};
    assign perr_w  = {if_n16.parity_error, if_n4.parity_error, if_n1.parity_error};
    assign ferr_w  = {if_n16.framing_error, if_n4.framing_error, if_n1.framing_error};
    assign data_w[0] = if_n1.RX_DATA;
    assign data_w[1] = if_n4.RX_DATA;
    assign data_w[2] = if_n16.RX_DATA;

    function automatic int unsigned n_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int unsigned h_of(input int sel);
        return (n_of(sel) - 1) / 2;
    endfunction

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic idle(input int sel, input int k);
        rx_line[sel] = 1'b1;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; a low stop bit is held low for 'hold' extra cycles then released.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                              input logic s, input int hold);
        logic [10:0] frame;
        exp_t e;
        int unsigned n;
        n = n_of(sel);
        frame = {s, p, d, 1'b0};
        e.sel  = sel;
        e.data = d;
        e.perr = (^d) ^ p;
        e.ferr = ~s;
        // Start is first seen on the next edge; strobe follows the stop-sample edge.
        e.cyc  = cyc + 1 + h_of(sel) + 10 * n;
        exp_q.push_back(e);
        for (int i = 0; i < 11; i++) begin
            rx_line[sel] = frame[i];
            repeat (n) @(posedge clk);
            #1;
        end
        if (!s) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            check_eq("brk_busy", busy_w[sel], 1);
            rx_line[sel] = 1'b1;
            @(posedge clk);
            #1;
            check_eq("brk_exit", busy_w[sel], 0);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (valid_w[k]) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexp_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("valid_inst", k, e.sel);
                    check_eq("rx_data", data_w[k], e.data);
                    check_eq("parity_err", perr_w[k], e.perr);
                    check_eq("framing_err", ferr_w[k], e.ferr);
                    check_eq("latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic        p, s;
        logic [10:0] frame;
        int unsigned e0;

        rx_line = '1;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_data", data_w[k], 0);
            check_eq("rst_valid", valid_w[k], 0);
            check_eq("rst_perr", perr_w[k], 0);
            check_eq("rst_ferr", ferr_w[k], 0);
            check_eq("rst_busy", busy_w[k], 0);
        end

        // Known-good byte, then bad parity followed back-to-back by good parity.
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
        idle(0, 2);
        send_frame(0, 8'h01, 1'b0, 1'b1, 0);
        send_frame(0, 8'h01, 1'b1, 1'b1, 0);
        idle(0, 3);

        // Short glitch at 16 clocks per bit: rejected at the half-bit check.
        rx_line[2] = 1'b0;
        e0 = cyc + 1;
        repeat (3) @(posedge clk);
        #1;
        rx_line[2] = 1'b1;
        check_eq("glitch_busy", busy_w[2], 1);
        repeat (6) @(posedge clk);
        #1;
        check_eq("glitch_idle", busy_w[2], 0);
        check_eq("glitch_edges", cyc - e0, 8);
        idle(2, 4);
        send_frame(2, 8'h96, 1'b0, 1'b1, 0);
        idle(2, 3);

        // Framing error with a long break, then a clean byte.
        send_frame(1, 8'h3C, 1'b0, 1'b0, 20);
        idle(1, 2);
        send_frame(1, 8'h55, 1'b0, 1'b1, 0);
        idle(1, 3);

        // Reset while D3 is on the line abandons the frame.
        d = 8'hA7;
        frame = {1'b1, ^d, d, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx_line[0] = frame[i];
            @(posedge clk);
            #1;
            if (i == 2) check_eq("mid_busy", busy_w[0], 1);
        end
        rx_line[0] = frame[4];
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx_line[0] = 1'b1;
        check_eq("mid_rst_data", data_w[0], 0);
        check_eq("mid_rst_valid", valid_w[0], 0);
        check_eq("mid_rst_perr", perr_w[0], 0);
        check_eq("mid_rst_ferr", ferr_w[0], 0);
        check_eq("mid_rst_busy", busy_w[0], 0);
        idle(0, 2);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
        idle(0, 2);

        // Random frames with occasional bad parity, bad stop and zero gaps.
        for (int sel = 0; sel < 3; sel++) begin
            for (int f = 0; f < ((sel == 2) ? 3 : 20); f++) begin
                d = 8'($urandom);
                p = (^d) ^ ($urandom_range(0, 3) == 0);
                s = ($urandom_range(0, 4) != 0);
                send_frame(sel, d, p, s, int'($urandom_range(0, 6)));
                idle(sel, int'($urandom_range(0, 2)));
            end
            idle(sel, 2);
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check_eq("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive path; consumes the single-bit line driven by the team's UART transmitter (`TX_dataout`) and recovers the 8-bit byte.
- Checks the even-parity bit and the stop bit, and presents the byte with a one-cycle valid strobe and error flags.
- Intended for same-clock loopback and for board RX pins driven from an already-synchronised source.
- No input synchroniser inside: `RX_datain` must be synchronous to `clk`.

Parameters:
- `CLKS_PER_BIT`, default 1: `clk` cycles per serial bit; legal values are >= 1. The value 1 matches the transmitter shifting one bit per clock.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `RX_datain`  input  1  serial line; idles high.
- `RX_DATA`  output  8  last received byte.
- `RX_valid`  output  1  one-cycle strobe: frame complete.
- `parity_error`  output  1  parity mismatch for the last frame.
- `framing_error`  output  1  stop bit sampled low for the last frame.
- `RX_busy`  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Frame format (fixed): start bit 0, D0..D7 LSB first, even-parity bit, stop bit 1. Even parity means D0^..^D7^P == 0.
- Reset: on a `clk` edge with `reset`=1, the FSM goes to IDLE and the bit/clock counters clear. `RX_DATA`=8'h00; `RX_valid`, `parity_error`, `framing_error` and `RX_busy` are all 0. Reset mid-frame abandons the frame with no strobe.
- Sample timing:
  - N = `CLKS_PER_BIT`, H = (N-1)/2 (integer division).
  - E0 = first edge in IDLE at which `RX_datain`==0.
  - Start bit is re-checked at E0+H. For N=1, H=0 and the detection itself counts as the check.
  - Data bit i (0..7) is sampled at E0+H+(i+1)·N.
  - Parity is sampled at E0+H+9N; stop is sampled at E0+H+10N.
- FSM states:
  - IDLE: `RX_busy`=0. Goes to START on `RX_datain`==0.
  - START: wait H cycles, then sample. A sample of 1 is a glitch: return to IDLE with no strobe and no flag change. A sample of 0 goes to DATA.
  - DATA: 8 samples, each N cycles apart, shifted into a shift register LSB first.
  - PARITY: one sample after N cycles.
  - STOP: one sample after N cycles.
    - Stop bit 1: go to IDLE.
    - Stop bit 0: go to BREAK.
  - BREAK: stay until `RX_datain`==1, then go to IDLE. A new start is not detected while in BREAK.
- Outputs at the stop-sample edge (all registered, so they are visible the following cycle):
  - `RX_DATA` <= shift register.
  - `RX_valid` <= 1 for exactly one cycle.
  - `parity_error` <= (^data) ^ parity_sample.
  - `framing_error` <= ~stop_sample.
- A byte with errors still strobes `RX_valid` and updates `RX_DATA`.
- `RX_DATA` and both error flags hold their values until the next `RX_valid` or `reset`.
- Latency: `RX_valid` is high in the cycle following edge E0+H+10N.
- Back-to-back frames: the FSM is in IDLE after the stop edge, so a start bit at edge E0+H+10N+1 (the next cycle) is accepted. This supports continuous transmitter output at N=1.
- `RX_datain` activity during `RX_valid` is handled normally; no frame is dropped.
- Counters:
  - Clock counter: $clog2(N+1) bits, reloaded at each sample.
  - Bit counter: 3 bits, counting 0..7 in DATA.

Test Plan:
- Reset, then drive idle 1 for 5 cycles -> all outputs 0; `RX_busy`=0.
- N=1: frame 0,1,0,1,0,0,1,0,1,0,1 (byte 8'hA5, parity 0, stop 1) -> `RX_valid` for 1 cycle after stop edge; `RX_DATA`=8'hA5; `parity_error`=0; `framing_error`=0.
- N=1: byte 8'h01 sent with parity bit 0 (wrong) -> `RX_DATA`=8'h01, `parity_error`=1. A following correct 8'h01 frame (parity 1) sent immediately after -> `parity_error` clears to 0 on its strobe.
- N=16: glitch low for 3 cycles, then high -> START aborts at the H=7 check; no `RX_valid`; FSM in IDLE.
- N=4: 8'h3C frame with stop bit 0, line held low for 20 cycles, then high -> `RX_valid` pulse, `framing_error`=1, `RX_busy` stays high until the line rises. A subsequent good 8'h55 frame -> `framing_error`=0.
- N=1: assert `reset` during D3 of a frame -> no `RX_valid`; outputs cleared. A following full frame 8'hFF (parity 0) is received correctly.
